// File: rtl/somador_pkg.sv
// somador_pkg: mode encodings, FSM states and saturation helper shared by the serial adder
package somador_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  // Signed saturation limit for a w-bit result (w <= 64): most negative when neg, else most positive
  function automatic logic [63:0] sat_value(input int w, input logic neg);
    logic [63:0] m;
    m = 64'd1 << (w - 1);
    return neg ? m : m - 64'd1;
  endfunction

endpackage

// File: rtl/somador_digit.sv
// somador_digit: combinational DIGIT-bit adder slice, also exposing the carry into its top bit
module somador_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_top
);

  logic [DIGIT:0] t;

  assign t     = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
  assign sum   = t[DIGIT-1:0];
  assign cout  = t[DIGIT];
  // sum bit = x ^ y ^ carry-in, so the carry into the top bit falls out of the sum
  assign c_top = x[DIGIT-1] ^ y[DIGIT-1] ^ sum[DIGIT-1];

endmodule

// File: rtl/somador_serial.sv
// somador_serial: digit-serial add/subtract with valid/ready handshakes; SOMADOR_SERIAL_SAT_EN enables signed saturation
module somador_serial
  import somador_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             v
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = NDIG > 1 ? $clog2(NDIG) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, mode_q, mode_d, co_q, co_d, v_q, v_d;
  logic [DIGIT-1:0] sum;
  logic             cout, ctop, ovf;

  somador_digit #(.DIGIT(DIGIT)) u_digit (
    .x     (a_q[DIGIT-1:0]),
    .y     (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .sum   (sum),
    .cout  (cout),
    .c_top (ctop)
  );

  // Signed overflow: carry into the MSB differs from carry out of it
  assign ovf = cout ^ ctop;
  assign s   = s_q;
  assign co  = co_q;
  assign v   = v_q;

  // Next state: capture operands in IDLE, consume one digit per RUN cycle, publish result into HOLD
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    s_d       = s_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    mode_d    = mode_q;
    co_d      = co_q;
    v_d       = v_q;
    in_ready  = state_q == IDLE;
    out_valid = state_q == HOLD;
    if (state_q == IDLE && in_valid) begin
      state_d = RUN;
      a_d     = a;
      b_d     = mode == MODE_SUB ? ~b : b;
      carry_d = mode == MODE_SUB ? ~ci : ci;
      mode_d  = mode;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      r_d     = WIDTH'({sum, r_q} >> DIGIT);
      carry_d = cout;
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == CW'(NDIG - 1)) begin
        state_d = HOLD;
        s_d     = r_d;
        co_d    = mode_q == MODE_SUB ? ~cout : cout;
        v_d     = ovf;
`ifdef SOMADOR_SERIAL_SAT_EN
        // On the last digit a_q[DIGIT-1] is still the original sign bit of a
        if (ovf) s_d = WIDTH'(sat_value(WIDTH, a_q[DIGIT-1]));
`endif
      end
    end else if (state_q == HOLD && out_ready) begin
      state_d = IDLE;
    end
  end

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      co_q    <= co_d;
      v_q     <= v_d;
    end
  end

endmodule

// File: tb/tb_somador_serial.sv
// tb_somador_serial: directed and random checks of somador_serial against an arithmetic model
module tb_somador_serial;

  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;
`ifdef SOMADOR_SERIAL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, ci = 1'b0, mode = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, co, v;
  logic [W-1:0] s;

  logic [7:0] a8 = '0, b8 = '0, s8a, s8b;
  logic       iv8 = 1'b0, or8 = 1'b0, ci8 = 1'b0, md8 = 1'b0;
  logic       ir8a, ir8b, ov8a, ov8b, co8a, co8b, v8a, v8b;

  int checks = 0;
  int errors = 0;

  somador_serial #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .ci(ci),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co), .v(v)
  );

  somador_serial #(.WIDTH(8), .DIGIT(8)) u8a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8a), .a(a8), .b(b8), .ci(ci8),
    .mode(md8), .out_valid(ov8a), .out_ready(or8), .s(s8a), .co(co8a), .v(v8a)
  );

  somador_serial #(.WIDTH(8), .DIGIT(1)) u8b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8b), .a(a8), .b(b8), .ci(ci8),
    .mode(md8), .out_valid(ov8b), .out_ready(or8), .s(s8b), .co(co8b), .v(v8b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {co, v, s}
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic m);
    logic [W:0]   t;
    logic [W-1:0] yp, r;
    logic         o, ov;
    yp = m ? ~y : y;
    if (!m) begin
      t = {1'b0, x} + {1'b0, y} + (W+1)'(c);
      r = t[W-1:0];
      o = t[W];
    end else begin
      r = x - y - W'(c);
      o = {1'b0, x} < ({1'b0, y} + (W+1)'(c));
    end
    ov = (x[W-1] == yp[W-1]) && (r[W-1] != x[W-1]);
    if (SAT && ov) r = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return {o, ov, r};
  endfunction

  logic [W+1:0] exp_v = '0;
  logic         pend = 1'b0, seen = 1'b0;
  int           ncyc = 0, acc = 0;

  // Scoreboard: every mid-cycle, check handshake state and held results against the model
  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      pend = 1'b0;
      seen = 1'b0;
    end else begin
      if (out_valid) begin
        if (!pend) chk("out_valid_unexpected", out_valid, 0);
        else begin
          chk("s", s, exp_v[W-1:0]);
          chk("co", co, exp_v[W+1]);
          chk("v", v, exp_v[W]);
          if (!seen) chk("latency", ncyc - acc, N + 1);
          seen = 1'b1;
        end
      end else if (seen) begin
        pend = 1'b0;
        seen = 1'b0;
      end
      chk("in_ready", in_ready, !pend);
      if (in_valid && in_ready) begin
        exp_v = model(a, b, ci, mode);
        pend  = 1'b1;
        acc   = ncyc;
      end
    end
  end

  // One full transaction; called and returns just after a rising edge
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic m,
                    input int hold, output logic [W-1:0] rs, output logic rco, output logic rv);
    int t;
    a = x; b = y; ci = c; mode = m; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
    chk("out_valid_timeout", t >= 50, 0);
    rs = s; rco = co; rv = v;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] rs;
    logic         rco, rv;
    logic [7:0]   sa[2], sb[2], es[2];
    logic         sm[2], eco[2], ev[2];
    int           t, la, lb;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_co", co, 0);
    chk("rst_v", v, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, rs, rco, rv);
    chk("add_wrap_s", rs, 16'h0000); chk("add_wrap_co", rco, 1); chk("add_wrap_v", rv, 0);
    op(16'h0005, 16'h0007, 1'b0, 1'b1, 1, rs, rco, rv);
    chk("sub_borrow_s", rs, 16'hFFFE); chk("sub_borrow_co", rco, 1); chk("sub_borrow_v", rv, 0);
    op(16'h0007, 16'h0005, 1'b1, 1'b1, 0, rs, rco, rv);
    chk("sub_bin_s", rs, 16'h0001); chk("sub_bin_co", rco, 0);
    op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, rs, rco, rv);
    chk("ovf_add_s", rs, SAT ? 16'h7FFF : 16'h8000); chk("ovf_add_v", rv, 1); chk("ovf_add_co", rco, 0);
    op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, rs, rco, rv);
    chk("ovf_sub_s", rs, SAT ? 16'h8000 : 16'h7FFF); chk("ovf_sub_v", rv, 1); chk("ovf_sub_co", rco, 0);

    // Backpressure with a competing request held on the input
    a = 16'h0100; b = 16'h0023; ci = 1'b0; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h4000; b = 16'h0001; mode = 1'b1;
    t = 0;
    while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
    chk("bp_timeout", t >= 50, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_s", s, 16'h0123);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_taken", in_ready, 0);
    t = 0;
    while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
    chk("bp2_timeout", t >= 50, 0);
    chk("bp2_s", s, 16'h3FFF);
    chk("bp2_co", co, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset two cycles into RUN
    a = 16'hABCD; b = 16'h1111; ci = 1'b0; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_s", s, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_co", co, 0);
    repeat (6) begin @(posedge clk); #1; end
    chk("mid_rst_no_result", out_valid, 0);
    op(16'h1234, 16'h1111, 1'b0, 1'b0, 0, rs, rco, rv);
    chk("post_rst_s", rs, 16'h2345); chk("post_rst_co", rco, 0);

    for (int i = 0; i < 1500; i++)
      op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         $urandom_range(0, 2), rs, rco, rv);

    // Parameter sweep: 8/8 (one RUN cycle) and 8/1 (eight RUN cycles)
    sa = '{8'd200, 8'd100}; sb = '{8'd100, 8'd200}; sm = '{1'b0, 1'b1};
    es = '{8'h2C, SAT ? 8'h7F : 8'h9C}; eco = '{1'b1, 1'b1}; ev = '{1'b0, 1'b1};
    for (int j = 0; j < 2; j++) begin
      a8 = sa[j]; b8 = sb[j]; md8 = sm[j]; iv8 = 1'b1;
      chk("sw_ready_a", ir8a, 1);
      chk("sw_ready_b", ir8b, 1);
      @(posedge clk); #1;
      iv8 = 1'b0;
      la = 0; lb = 0;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        if (ov8a && la == 0) la = k;
        if (ov8b && lb == 0) lb = k;
      end
      chk("sw_lat_8x8", la, 1);
      chk("sw_lat_8x1", lb, 8);
      chk("sw_s_8x8", s8a, es[j]); chk("sw_co_8x8", co8a, eco[j]); chk("sw_v_8x8", v8a, ev[j]);
      chk("sw_s_8x1", s8b, es[j]); chk("sw_co_8x1", co8b, eco[j]); chk("sw_v_8x1", v8b, ev[j]);
      or8 = 1'b1;
      @(posedge clk); #1;
      or8 = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
